bcd_sub_serial: RTL and testbench
=================================

# bcd_sub_serial

Digit-serial multi-digit BCD subtractor with start/done handshake. It computes `diff = a − b − bin` over `DIGITS` packed BCD digits, one digit per clock, least significant digit first, and reports the final borrow. It is the subtraction counterpart of the team's BCD adder blocks and sits in the same datapath for decimal counters and display arithmetic.

## Interface
- `DIGITS`, default 2: number of BCD digits per operand; legal range 1–8.
- `clk` in 1: system clock, rising-edge active.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `a` in 4*DIGITS: minuend, packed BCD, digit i in bits [4i+3:4i].
- `b` in 4*DIGITS: subtrahend, packed BCD.
- `bin` in 1: borrow-in.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `diff` and `bout` are valid from this cycle on.
- `diff` out 4*DIGITS: result digits, registered and held until the next accepted start.
- `bout` out 1: final borrow. 1 when `a < b + bin` as decimal values.
- `err` out 1: only exists when `BCD_SUB_INVALID_CHECK_EN` is defined; see Configuration.

## Operation
- **States:** IDLE, SUB.
- **IDLE, start=1:**
  - Capture `a`, `b` and `bin` into internal registers.
  - Clear the digit index to 0 and load the borrow register with `bin`.
  - Go to SUB.
- **IDLE, start=0:** remain in IDLE. All outputs hold.
- **SUB, each cycle, digit i:**
  - Compute `t = a_i − b_i − borrow` as a 5-bit signed value.
  - If `t < 0`: write `t + 10` to digit i of `diff`, and set borrow to 1.
  - Otherwise: write `t` to digit i, and set borrow to 0.
  - Increment i.
- **Last digit (i = DIGITS−1):**
  - Write `bout` from the final borrow.
  - Go to IDLE and pulse `done`.
- **Result range:** `diff = (a − b − bin) mod 10^DIGITS`.
  - Negative results appear in ten's-complement form with `bout=1`.
  - Example: 17 − 42 gives `diff=75`, `bout=1`.
- **Operand stability:** inputs are not required to stay stable after start is accepted; only the captured copies are used.
- **start while busy:** ignored; no queuing.
- **start during the done cycle:** accepted, because the state is already IDLE. `done` still pulses for the finished operation.
- **Partial results:** digits of `diff` are updated in place during SUB. `diff` is valid only from `done` until the next accepted start.

## Timing
- **Reset values:** `busy=0`, `done=0`, `diff=0`, `bout=0`, `err=0`, state IDLE, index 0.
- **Reset mid-operation:** returns to the reset values immediately (asynchronous). No `done` is produced.
- **Latency:** start is sampled at edge E0. `busy=1` from E0. Digits are computed at edges E1…E_DIGITS.
- **At edge E_DIGITS:**
  - Final `diff` and `bout` are registered.
  - `busy` falls to 0.
  - `done` rises to 1.
- **done pulse:** `done` clears at E_DIGITS+1 unless another operation completes there.
- **Throughput:** one operation every DIGITS+1 cycles with back-to-back starts. With start held high continuously, a new operation begins on every done cycle.
- **Register boundaries:** all outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **Macro:** `BCD_SUB_INVALID_CHECK_EN`.
- **When defined:**
  - The `err` port exists.
  - At capture, `err_pending` is set if any digit of `a` or `b` exceeds 9.
  - `err` is registered alongside `done` and held with `diff` until the next accepted start.
  - Arithmetic proceeds unchanged, so `diff` digits are then unspecified but deterministic.
- **When undefined:**
  - There is no `err` port and no check logic.
  - Invalid digits yield unspecified `diff` values.

## Test plan
- DIGITS=2, `a=0x42`, `b=0x17`, `bin=0`, start one cycle -> `done` exactly 2 edges after the start edge, `diff=0x25`, `bout=0`, `busy` high for those 2 cycles.
- `a=0x17`, `b=0x42`, `bin=0` -> `diff=0x75`, `bout=1`; `a=0x00`, `b=0x00`, `bin=1` -> `diff=0x99`, `bout=1`.
- `a=0x50`, `b=0x50`, `bin=0` -> `diff=0x00`, `bout=0`; start pulsed again during busy -> ignored, exactly one `done`.
- Start held high for 3 operations with changing operands -> `done` every 3 cycles, each result matches the operands captured at its own start edge.
- Deassert `rst_n` at the E1 edge (mid-operation) -> all outputs 0 immediately; no `done` after release; the next start completes normally.
- With `BCD_SUB_INVALID_CHECK_EN`: `a=0x3A`, `b=0x01` -> `err=1` with `done`; a following valid operation -> `err=0`.

Source files
------------

// File: rtl/bcd_sub_serial_if.sv
// ============================================================================
// Module : bcd_sub_serial_if
// Brief  : start/done bus of the digit-serial BCD subtractor. The err signal
//          exists only when BCD_SUB_INVALID_CHECK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_sub_serial_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  bout;
`ifdef BCD_SUB_INVALID_CHECK_EN
  logic                  err;

  modport master (output start, a, b, bin, input busy, done, diff, bout, err);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, err);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

`default_nettype wire

// File: rtl/bcd_sub_serial.sv
// ============================================================================
// Module : bcd_sub_serial
// Brief  : digit-serial BCD subtractor, diff = a - b - bin, LSD first, one
//          digit per clock. Optional macro BCD_SUB_INVALID_CHECK_EN adds err.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_sub_serial #(
  parameter int DIGITS = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  bcd_sub_serial_if.slave bus
);
  localparam int c_width = 4 * DIGITS;
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SUB  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_last;

  logic [c_width-1:0]   r_a;
  logic [c_width-1:0]   r_b;
  logic                 r_borrow;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_width-1:0]   r_diff;
  logic                 r_bout;
  logic                 r_done;
  logic [4:0]           w_t;
  logic [3:0]           w_dig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SUB;
        end
      end
      S_SUB: begin
        w_last = (r_idx == c_last_idx);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands shift right each step, so the active digit is always in [3:0].
  always_comb begin
    w_t   = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'b0000, r_borrow};
    w_dig = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_borrow <= bus.bin;
        r_idx    <= '0;
      end else if (r_state == S_SUB) begin
        r_a      <= r_a >> 4;
        r_b      <= r_b >> 4;
        r_borrow <= w_t[4];
        r_idx    <= w_last ? '0 : r_idx + 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
          if (r_idx == c_idx_w'(k)) r_diff[4*k +: 4] <= w_dig;
        end
        if (w_last) r_bout <= w_t[4];
      end
    end
  end

`ifdef BCD_SUB_INVALID_CHECK_EN
  logic r_err_pending;
  logic r_err;
  logic w_cap_err;

  always_comb begin
    w_cap_err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((bus.a[4*k +: 4] > 4'd9) || (bus.b[4*k +: 4] > 4'd9)) w_cap_err = 1'b1;
    end
  end

  // err is published with done and cleared when the next operation starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pending <= 1'b0;
      r_err         <= 1'b0;
    end else if (w_accept) begin
      r_err_pending <= w_cap_err;
      r_err         <= 1'b0;
    end else if (w_last) begin
      r_err         <= r_err_pending;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.busy = (r_state == S_SUB);
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_bcd_sub_serial.sv
// ============================================================================
// Module : tb_bcd_sub_serial
// Brief  : self-checking bench for bcd_sub_serial against a decimal model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_sub_serial;
  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bcd_sub_serial_if #(.DIGITS(DIGITS)) bus ();
  bcd_sub_serial #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Decimal reference: plain integer subtraction, wrapped modulo 10^DIGITS.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo);
    int m = 1;
    int r;
    repeat (DIGITS) m = m * 10;
    r  = bcd2int(a) - bcd2int(b) - int'(bin);
    bo = (r < 0);
    if (r < 0) r = r + m;
    d  = int2bcd(r);
  endtask

  // Runs one operation and returns what was observed; callers do the checks.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bo, output logic er,
                        output int lat, output int busy_cnt, output logic pulse_ok);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    @(posedge clk);
    lat = 0; busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      lat++;
      @(negedge clk);
    end
    d  = bus.diff;
    bo = bus.bout;
`ifdef BCD_SUB_INVALID_CHECK_EN
    er = bus.err;
`else
    er = 1'b0;
`endif
    @(negedge clk);
    pulse_ok = !bus.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.bout} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl busy/done/bout got %b expected 000", {bus.busy, bus.done, bus.bout});
    end
    n_cmp++;
    if (bus.diff !== '0) begin
      n_fail++;
      $display("FAIL reset_diff got %h expected 0", bus.diff);
    end
`ifdef BCD_SUB_INVALID_CHECK_EN
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b expected 0", bus.err);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] av[3] = '{8'h42, 8'h17, 8'h00};
    logic [W-1:0] bv[3] = '{8'h17, 8'h42, 8'h00};
    logic         cv[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] d, ed;
    logic bo, ebo, er, pok;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      model(av[i], bv[i], cv[i], ed, ebo);
      run_op(av[i], bv[i], cv[i], d, bo, er, lat, bc, pok);
      n_cmp++;
      if (d !== ed) begin n_fail++; $display("FAIL dir[%0d] diff got %h expected %h", i, d, ed); end
      n_cmp++;
      if (bo !== ebo) begin n_fail++; $display("FAIL dir[%0d] bout got %b expected %b", i, bo, ebo); end
      n_cmp++;
      if (lat !== DIGITS) begin n_fail++; $display("FAIL dir[%0d] latency got %0d expected %0d", i, lat, DIGITS); end
      n_cmp++;
      if (bc !== DIGITS) begin n_fail++; $display("FAIL dir[%0d] busy_cycles got %0d expected %0d", i, bc, DIGITS); end
      n_cmp++;
      if (pok !== 1'b1) begin n_fail++; $display("FAIL dir[%0d] done_pulse got long expected 1 cycle", i); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] ed;
    logic ebo;
    int dones = 0;
    model(8'h50, 8'h50, 1'b0, ed, ebo);
    @(negedge clk);
    bus.a = 8'h50; bus.b = 8'h50; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 8'h99; bus.b = 8'h01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done) dones++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 1) begin n_fail++; $display("FAIL busy_start done_count got %0d expected 1", dones); end
    n_cmp++;
    if (bus.diff !== ed) begin n_fail++; $display("FAIL busy_start diff got %h expected %h", bus.diff, ed); end
    n_cmp++;
    if (bus.bout !== ebo) begin n_fail++; $display("FAIL busy_start bout got %b expected %b", bus.bout, ebo); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, d, ed;
    logic c, bo, ebo, er, pok;
    int lat, bc;
    for (int i = 0; i < 20; i++) begin
      a = rand_bcd(); b = rand_bcd(); c = 1'($urandom);
      model(a, b, c, ed, ebo);
      run_op(a, b, c, d, bo, er, lat, bc, pok);
      n_cmp++;
      if ({bo, d} !== {ebo, ed}) begin
        n_fail++;
        $display("FAIL rand[%0d] %h-%h-%b bout/diff got %b/%h expected %b/%h", i, a, b, c, bo, d, ebo, ed);
      end
      n_cmp++;
      if (lat !== DIGITS) begin n_fail++; $display("FAIL rand[%0d] latency got %0d expected %0d", i, lat, DIGITS); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av[3], bv[3], ed;
    logic cv[3];
    logic ebo;
    int lat;
    for (int i = 0; i < 3; i++) begin
      av[i] = rand_bcd(); bv[i] = rand_bcd(); cv[i] = 1'($urandom);
    end
    @(negedge clk);
    bus.a = av[0]; bus.b = bv[0]; bus.bin = cv[0]; bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 2) begin
        bus.a = av[k+1]; bus.b = bv[k+1]; bus.bin = cv[k+1];
      end else begin
        bus.start = 1'b0;
      end
      lat = 0;
      while (!bus.done && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      model(av[k], bv[k], cv[k], ed, ebo);
      n_cmp++;
      if (lat !== DIGITS) begin n_fail++; $display("FAIL b2b[%0d] latency got %0d expected %0d", k, lat, DIGITS); end
      n_cmp++;
      if ({bus.bout, bus.diff} !== {ebo, ed}) begin
        n_fail++;
        $display("FAIL b2b[%0d] bout/diff got %b/%h expected %b/%h", k, bus.bout, bus.diff, ebo, ed);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] d, ed;
    logic bo, ebo, er, pok;
    int lat, bc;
    int dones = 0;
    @(negedge clk);
    bus.a = 8'h83; bus.b = 8'h27; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.bout} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_ctl busy/done/bout got %b expected 000", {bus.busy, bus.done, bus.bout});
    end
    n_cmp++;
    if (bus.diff !== '0) begin n_fail++; $display("FAIL midrst_diff got %h expected 0", bus.diff); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrst_nodone got %0d dones expected 0", dones); end
    model(8'h61, 8'h09, 1'b1, ed, ebo);
    run_op(8'h61, 8'h09, 1'b1, d, bo, er, lat, bc, pok);
    n_cmp++;
    if ({bo, d} !== {ebo, ed}) begin
      n_fail++;
      $display("FAIL midrst_next bout/diff got %b/%h expected %b/%h", bo, d, ebo, ed);
    end
  endtask

`ifdef BCD_SUB_INVALID_CHECK_EN
  task automatic test_invalid_check();
    logic [W-1:0] d;
    logic bo, er, pok;
    int lat, bc;
    run_op(8'h3A, 8'h01, 1'b0, d, bo, er, lat, bc, pok);
    n_cmp++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_set got %b expected 1", er); end
    n_cmp++;
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_hold got %b expected 1", bus.err); end
    run_op(8'h35, 8'h01, 1'b0, d, bo, er, lat, bc, pok);
    n_cmp++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b expected 0", er); end
    n_cmp++;
    if (d !== 8'h34) begin n_fail++; $display("FAIL err_clear_diff got %h expected 34", d); end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
`ifdef BCD_SUB_INVALID_CHECK_EN
    test_invalid_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t expected bench to finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
